// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, FSM encodings and default timing for the pipeline sequencing controller.
// Pure declarations; no logic, no latency, no flow control.
package hazard_ctrl_pkg;

  localparam int HC_ASIZE     = 4;
  localparam int HC_FLUSH_CYC = 2;
  localparam int HC_MUL_LAT   = 4;
  localparam int HC_CNT_W     = 16;
  // Holds MUL_LAT-3 for the largest supported latency (15).
  localparam int HC_SEQ_W     = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_MUL   = 2'd2
  } hc_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; count visible one cycle after inc.
// Never back-pressures: an increment at all-ones is dropped.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Per-cycle advance/hold/bubble decisions for PC, IF/ID, ID/EXE, EXE/MEM; outputs are same-cycle (Mealy).
// Stalls the front end for load-use and multiply, flushes after redirect; counts non-advancing cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ASIZE     = HC_ASIZE,
  parameter int FLUSH_CYC = HC_FLUSH_CYC,
  parameter int MUL_LAT   = HC_MUL_LAT,
  parameter int CNT_W     = HC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] ifid_rs,
  input  logic [ASIZE-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idexe_memRead,
  input  logic [ASIZE-1:0] idexe_waddr,
  input  logic             exe_is_mul,
  input  logic             redirect,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idexe_hold,
  output logic             idexe_bubble,
  output logic             exmem_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles
);

  // The detecting RUN cycle is the first hold/flush cycle, so the extra
  // state cycles are FLUSH_CYC-1 and MUL_LAT-2 (the multiply advances on the MUL_LAT-th).
  localparam logic [HC_SEQ_W-1:0] L_FLUSH_CNT = HC_SEQ_W'(FLUSH_CYC > 1 ? FLUSH_CYC - 2 : 0);
  localparam logic [HC_SEQ_W-1:0] L_MUL_CNT   = HC_SEQ_W'(MUL_LAT > 2 ? MUL_LAT - 3 : 0);

  hc_state_t            r_state;
  logic [HC_SEQ_W-1:0]  r_cnt;
  hc_state_t            w_next_state;
  logic [HC_SEQ_W-1:0]  w_next_cnt;
  logic                 w_load_use;
  logic                 w_stall_inc;

  assign w_load_use = idexe_memRead && (idexe_waddr != '0) &&
                      ((idexe_waddr == ifid_rs) || (ifid_uses_rt && (idexe_waddr == ifid_rt)));

  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idexe_hold   = 1'b0;
    idexe_bubble = 1'b0;
    exmem_bubble = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (redirect) begin
          ifid_flush   = 1'b1;
          idexe_bubble = 1'b1;
          if (FLUSH_CYC > 1) begin
            w_next_state = ST_FLUSH;
            w_next_cnt   = L_FLUSH_CNT;
          end
        end else if (exe_is_mul) begin
          pc_hold      = 1'b1;
          ifid_hold    = 1'b1;
          idexe_hold   = 1'b1;
          exmem_bubble = 1'b1;
          if (MUL_LAT > 2) begin
            w_next_state = ST_MUL;
            w_next_cnt   = L_MUL_CNT;
          end
        end else if (w_load_use) begin
          pc_hold      = 1'b1;
          ifid_hold    = 1'b1;
          idexe_bubble = 1'b1;
        end
      end
      ST_FLUSH: begin
        ifid_flush   = 1'b1;
        idexe_bubble = 1'b1;
        if (r_cnt == '0) w_next_state = ST_RUN;
        else             w_next_cnt   = r_cnt - 1'b1;
      end
      ST_MUL: begin
        pc_hold      = 1'b1;
        ifid_hold    = 1'b1;
        idexe_hold   = 1'b1;
        exmem_bubble = 1'b1;
        if (r_cnt == '0) w_next_state = ST_RUN;
        else             w_next_cnt   = r_cnt - 1'b1;
      end
      default: begin
        w_next_state = ST_RUN;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  assign busy        = (r_state != ST_RUN);
  assign w_stall_inc = pc_hold | ifid_flush | exmem_bubble;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_stall_inc),
    .o_cnt   (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench: expected outputs are queued as each cycle is driven and checked before the edge.
module tb_hazard_ctrl;

  localparam int ASIZE = 4;
  localparam int FLUSH_CYC = 2;
  localparam int MUL_LAT = 4;
  localparam int CNT_W = 4;
  localparam int SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [ASIZE-1:0] ifid_rs, ifid_rt, idexe_waddr;
  logic ifid_uses_rt, idexe_memRead, exe_is_mul, redirect;
  logic pc_hold, ifid_hold, ifid_flush, idexe_hold, idexe_bubble, exmem_bubble, busy;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_ctrl #(.ASIZE(ASIZE), .FLUSH_CYC(FLUSH_CYC), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idexe_memRead(idexe_memRead), .idexe_waddr(idexe_waddr),
    .exe_is_mul(exe_is_mul), .redirect(redirect),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idexe_hold(idexe_hold), .idexe_bubble(idexe_bubble), .exmem_bubble(exmem_bubble),
    .busy(busy), .stall_cycles(stall_cycles)
  );

  typedef struct {
    string      tag;
    logic [6:0] ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model: remaining extra flush / multiply cycles and the stall count.
  int m_fl = 0, m_ml = 0, m_st = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // ctl = {pc_hold, ifid_hold, ifid_flush, idexe_hold, idexe_bubble, exmem_bubble, busy}
  task automatic step(input string tag, input logic rst_v, input logic mr, input logic [3:0] wa,
                      input logic [3:0] rs, input logic [3:0] rt, input logic ur,
                      input logic mul, input logic rd);
    exp_t e;
    logic lu, ph, ih, ifl, ieh, ieb, exb, bz;
    int nfl, nml, nst;
    @(negedge clk);
    rst = rst_v; idexe_memRead = mr; idexe_waddr = wa; ifid_rs = rs; ifid_rt = rt;
    ifid_uses_rt = ur; exe_is_mul = mul; redirect = rd;

    lu = mr && (wa != 0) && ((wa == rs) || (ur && (wa == rt)));
    {ph, ih, ifl, ieh, ieb, exb} = '0;
    bz = (m_fl > 0) || (m_ml > 0);
    nfl = m_fl; nml = m_ml;
    if (m_fl > 0) begin
      ifl = 1; ieb = 1; nfl = m_fl - 1;
    end else if (m_ml > 0) begin
      ph = 1; ih = 1; ieh = 1; exb = 1; nml = m_ml - 1;
    end else if (rd) begin
      ifl = 1; ieb = 1; nfl = FLUSH_CYC - 1;
    end else if (mul) begin
      ph = 1; ih = 1; ieh = 1; exb = 1; nml = MUL_LAT - 2;
    end else if (lu) begin
      ph = 1; ih = 1; ieb = 1;
    end
    nst = (ph || ifl || exb) ? ((m_st < SAT) ? m_st + 1 : SAT) : m_st;
    if (!rst_v) begin
      nfl = 0; nml = 0; nst = 0;
    end

    e.tag = tag;
    e.ctl = {ph, ih, ifl, ieh, ieb, exb, bz};
    e.cnt = CNT_W'(m_st);
    sb_q.push_back(e);

    #1;
    e = sb_q.pop_front();
    check_eq({e.tag, ".ctl"}, 32'({pc_hold, ifid_hold, ifid_flush, idexe_hold,
                                   idexe_bubble, exmem_bubble, busy}), 32'(e.ctl));
    check_eq({e.tag, ".cnt"}, 32'(stall_cycles), 32'(e.cnt));

    @(posedge clk);
    m_fl = nfl; m_ml = nml; m_st = nst;
  endtask

  task automatic idle(input string tag);
    step(tag, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 0; idexe_memRead = 0; idexe_waddr = 0; ifid_rs = 0; ifid_rt = 0;
    ifid_uses_rt = 0; exe_is_mul = 0; redirect = 0;
    repeat (2) @(posedge clk);

    idle("reset_state");
    // load-use on rs, then on rt, then the filtered cases
    step("lu_rs", 1, 1, 3, 3, 0, 0, 0, 0);
    idle("lu_after");
    step("waddr0", 1, 1, 0, 0, 0, 0, 0, 0);
    step("rt_unused", 1, 1, 5, 1, 5, 0, 0, 0);
    step("lu_rt", 1, 1, 5, 1, 5, 1, 0, 0);
    step("no_load", 1, 0, 5, 5, 0, 0, 0, 0);
    // redirect with a second (ignored) redirect in the flush cycle
    step("redir_1", 1, 0, 0, 0, 0, 0, 0, 1);
    step("redir_2", 1, 0, 0, 0, 0, 0, 0, 1);
    idle("redir_done");
    // multiply occupancy
    step("mul_1", 1, 0, 0, 0, 0, 0, 1, 0);
    step("mul_2", 1, 1, 3, 3, 0, 0, 0, 1);
    idle("mul_3");
    idle("mul_exit");
    // priority: redirect over load-use, redirect over multiply, multiply over load-use
    step("prio_rd_lu", 1, 1, 7, 7, 0, 0, 0, 1);
    idle("prio_rd_lu_2");
    step("prio_rd_mul", 1, 0, 0, 0, 0, 0, 1, 1);
    idle("prio_rd_mul_2");
    step("prio_mul_lu", 1, 1, 2, 2, 0, 0, 1, 0);
    repeat (2) idle("prio_mul_lu_n");
    idle("prio_mul_lu_x");
    // push the 4-bit counter well past saturation
    for (int i = 0; i < 20; i++) step("sat_lu", 1, 1, 4, 4, 0, 0, 0, 0);
    idle("sat_after");
    check_eq("sat_value", 32'(stall_cycles), 32'(SAT));
    // reset in the middle of a multiply
    step("rst_mul_1", 1, 0, 0, 0, 0, 0, 1, 0);
    step("rst_mul_2", 0, 0, 0, 0, 0, 0, 0, 0);
    idle("rst_after");
    check_eq("rst_cnt", 32'(stall_cycles), 32'(0));
    idle("rst_after_2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
